prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Receive-side counterpart to the LFSR generator: consumes a serial pseudo-random bit stream and self-synchronises a local LFSR to it.
- Declares lock once the stream is synchronised, then counts bit errors and unlocks on excessive errors.
- Sits downstream of the generator (or a link under test) and feeds the board status display: lock LED, error LED and error/bit counters.

Parameters:
- WIDTH, 16: LFSR register width in bits.
- TAPS, 16'hB400: Fibonacci feedback mask for x^16+x^14+x^13+x^11+1; bit k set means r[k] feeds the XOR.
- LOCK_COUNT, 32: consecutive correct predictions required to enter LOCKED.
- WINDOW, 64: valid-beat window length used for the loss-of-lock check.
- UNLOCK_ERRS, 8: error count within one window that forces resynchronisation.
- CNT_W, 16: width of both statistics counters.

Ports:
- i_clk, in, 1: clock; all logic on the rising edge.
- i_rst, in, 1: asynchronous, active-high reset.
- i_valid, in, 1: i_bit carries a stream bit this cycle.
- i_bit, in, 1: received stream bit.
- i_clear, in, 1: synchronous clear of o_err_cnt and o_bit_cnt.
- o_locked, out, 1: checker is synchronised.
- o_err, out, 1: one-cycle pulse marking a mismatched bit while LOCKED.
- o_err_cnt, out, CNT_W: saturating count of errors seen while LOCKED.
- o_bit_cnt, out, CNT_W: saturating count of valid beats seen while LOCKED.

Behaviour:
- Reset: all outputs 0; state SEED; LFSR register r = 0; fill, match, window and window-error counters = 0.
- Prediction: p = XOR-reduce(r & TAPS). Step: r_next = {r[WIDTH-2:0], x}.
  - In SEED and ACQ, x = i_bit (register tracks the received stream).
  - In LOCKED, x = p (flywheel; received errors never corrupt the register).
- Nothing changes on cycles with i_valid=0, except i_clear, which acts regardless of i_valid.
- SEED:
  - Each valid beat shifts i_bit into r and increments the fill counter.
  - After WIDTH beats, go to ACQ if r_next != 0; otherwise stay in SEED with the fill counter restarted.
- ACQ:
  - Compare i_bit with p on each valid beat.
  - Match: increment the match counter. On the LOCK_COUNT-th consecutive match, go to LOCKED. o_locked rises the cycle after that beat.
  - Mismatch: clear the match counter and return to SEED with the fill counter at 0. The beat's bit is still shifted in, but the refill restarts from zero.
- LOCKED, per valid beat:
  - o_bit_cnt increments, saturating at all-ones.
  - On mismatch: o_err=1 in the next cycle; o_err_cnt and the window-error counter increment, o_err_cnt saturating.
  - The window counter advances each valid beat.
  - If the window-error count reaches UNLOCK_ERRS, go to SEED on that beat. o_locked falls the next cycle; window, match and fill counters clear.
  - On the WINDOW-th beat the window and window-error counters reset to 0. An error on that final beat counts toward the closing window first.
- o_err is 0 outside LOCKED; no errors are counted in SEED or ACQ.
- i_clear:
  - Zeroes o_err_cnt and o_bit_cnt next cycle and has priority over a simultaneous increment; that beat's error or bit is not counted.
  - o_err still pulses for that beat.
  - Lock state is unaffected.
- Reset mid-operation: immediate return to reset values, regardless of state.
- Latency: every output is registered; all responses appear one cycle after the triggering valid beat.

Decomposition:
- Package prbs_pkg holds:
  - state enum prbs_state_e {SEED, ACQ, LOCKED};
  - default polynomial constants PRBS16_TAPS = 16'hB400 and PRBS4_TAPS = 4'b1100;
  - function lfsr_predict(r, taps) returning the XOR-reduced feedback bit.
- Sub-module prbs_predictor: holds r. Inputs are shift enable and a select between x = i_bit and x = p; outputs r and p. Shared in spirit with the generator.
- The top level holds the FSM and counters.

Test Plan:
- Lock acquisition, WIDTH=4, TAPS=4'b1100, LOCK_COUNT=8, seed 4'b0001, continuous valid: o_locked=0 for the first 4+7 beats and rises exactly one cycle after beat 12; o_err never pulses; o_err_cnt=0.
- Single error: after lock, invert 1 bit → exactly one o_err pulse one cycle later; o_err_cnt=1; o_locked stays 1. The next 20 correct bits give no further errors (flywheel check).
- Loss of lock, WINDOW=64, UNLOCK_ERRS=8: inject 8 inverted bits within 64 beats → o_locked falls the cycle after the 8th error; o_err_cnt=8. Re-lock occurs after WIDTH+LOCK_COUNT clean beats.
- Window boundary: 7 errors in window 1 (last one on beat 64), then 7 errors in window 2 → o_locked remains 1; o_err_cnt=14.
- Clear collision: with o_err_cnt=5, assert i_clear on the same beat as an error → o_err pulses, o_err_cnt=0 and o_bit_cnt=0 next cycle. The next error gives o_err_cnt=1.
- Abnormal input and reset:
  - All-zero stream: o_locked stays 0 and the checker remains in SEED indefinitely.
  - i_valid gaps of 1–3 cycles inserted during lock: behaviour identical to the gapless case.
  - Async i_rst asserted mid-LOCKED: all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared types, default polynomials and the feedback helper for the PRBS checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } prbs_state_e;

  localparam int unsigned MAX_W = 64;

  localparam logic [15:0] PRBS16_TAPS = 16'hB400;
  localparam logic [3:0]  PRBS4_TAPS  = 4'b1100;

  // Fibonacci feedback: XOR of every register bit selected by the tap mask.
  function automatic logic lfsr_predict(input logic [MAX_W-1:0] r,
                                        input logic [MAX_W-1:0] taps);
    return ^(r & taps);
  endfunction

endpackage

// File: rtl/prbs_predictor.sv
// Local LFSR that either tracks the received stream or free-runs on its own
// prediction (flywheel) so that line errors cannot corrupt it.
module prbs_predictor
  import prbs_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = PRBS16_TAPS
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             shift_en,
  input  logic             sel_pred,
  input  logic             rx_bit,
  output logic [WIDTH-1:0] r,
  output logic             p_c
);

  logic x_c;

  assign p_c = lfsr_predict(MAX_W'(r), MAX_W'(TAPS));
  assign x_c = sel_pred ? p_c : rx_bit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r <= '0;
    end else if (shift_en) begin
      r <= {r[WIDTH-2:0], x_c};
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS receiver: seeds a local LFSR from the stream, declares
// lock after a run of correct predictions, then counts errors and drops lock
// when too many errors land inside one window.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] TAPS        = PRBS16_TAPS,
  parameter int unsigned      LOCK_COUNT  = 32,
  parameter int unsigned      WINDOW      = 64,
  parameter int unsigned      UNLOCK_ERRS = 8,
  parameter int unsigned      CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_bit_cnt
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WIN_W   = $clog2(WINDOW + 1);
  localparam int unsigned WERR_W  = $clog2(UNLOCK_ERRS + 1);

  prbs_state_e        state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [WERR_W-1:0]  werr_q, werr_d;
  logic [WERR_W-1:0]  werr_inc_c;

  logic [WIDTH-1:0]   r;
  logic               p_c;
  logic               mism_c;
  logic               seed_nz_c;

  logic               locked_d;
  logic               err_d;
  logic [CNT_W-1:0]   err_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_d;

  prbs_predictor #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_pred (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .shift_en (i_valid),
    .sel_pred (state_q == LOCKED),
    .rx_bit   (i_bit),
    .r        (r),
    .p_c      (p_c)
  );

  assign mism_c    = (i_bit != p_c);
  // Register contents after this beat when tracking the received stream.
  assign seed_nz_c = (((r << 1) | WIDTH'(i_bit)) != '0);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and sync counters
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    match_d    = match_q;
    win_d      = win_q;
    werr_d     = werr_q;
    werr_inc_c = werr_q + WERR_W'(mism_c);
    if (i_valid) begin
      unique case (state_q)
        SEED: begin
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_W'(WIDTH - 1)) begin
            fill_d = '0;
            if (seed_nz_c) begin
              state_d = ACQ;
            end
          end
        end
        ACQ: begin
          if (mism_c) begin
            match_d = '0;
            fill_d  = '0;
            state_d = SEED;
          end else if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
            state_d = LOCKED;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end
        LOCKED: begin
          if (werr_inc_c == WERR_W'(UNLOCK_ERRS)) begin
            win_d   = '0;
            werr_d  = '0;
            match_d = '0;
            fill_d  = '0;
            state_d = SEED;
          end else if (win_q == WIN_W'(WINDOW - 1)) begin
            // Closing beat: its error was already judged against this window.
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + WIN_W'(1);
            werr_d = werr_inc_c;
          end
        end
        default: begin
          state_d = SEED;
        end
      endcase
    end
  end

  // Output next values; clear wins over a same-cycle increment
  always_comb begin
    locked_d  = (state_d == LOCKED);
    err_d     = i_valid && (state_q == LOCKED) && mism_c;
    err_cnt_d = o_err_cnt;
    bit_cnt_d = o_bit_cnt;
    if (i_clear) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end else begin
      if (err_d && (o_err_cnt != '1)) begin
        err_cnt_d = o_err_cnt + CNT_W'(1);
      end
      if (i_valid && (state_q == LOCKED) && (o_bit_cnt != '1)) begin
        bit_cnt_d = o_bit_cnt + CNT_W'(1);
      end
    end
  end

  // Counter and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fill_q    <= '0;
      match_q   <= '0;
      win_q     <= '0;
      werr_q    <= '0;
      o_locked  <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
      o_bit_cnt <= '0;
    end else begin
      fill_q    <= fill_d;
      match_q   <= match_d;
      win_q     <= win_d;
      werr_q    <= werr_d;
      o_locked  <= locked_d;
      o_err     <= err_d;
      o_err_cnt <= err_cnt_d;
      o_bit_cnt <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker (4-bit polynomial x^4+x^3+1): directed scenarios plus
// randomized error/gap/clear traffic against a bit-history reference model.
module tb_prbs_checker;

  localparam int         W       = 4;
  localparam logic [3:0] TB_TAPS = 4'b1100;
  localparam int         LC      = 8;
  localparam int         WIN     = 64;
  localparam int         UE      = 8;
  localparam int         CW      = 16;
  localparam int         CMAX    = (1 << CW) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_bit = 1'b0;
  logic          i_clear = 1'b0;
  logic          o_locked;
  logic          o_err;
  logic [CW-1:0] o_err_cnt;
  logic [CW-1:0] o_bit_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  prbs_checker #(
    .WIDTH       (W),
    .TAPS        (TB_TAPS),
    .LOCK_COUNT  (LC),
    .WINDOW      (WIN),
    .UNLOCK_ERRS (UE),
    .CNT_W       (CW)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .i_bit     (i_bit),
    .i_clear   (i_clear),
    .o_locked  (o_locked),
    .o_err     (o_err),
    .o_err_cnt (o_err_cnt),
    .o_bit_cnt (o_bit_cnt)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- stream generator (true sequence, newest bit at index 0)
  bit gen_hist[$];

  function automatic bit gen_next();
    bit b = 1'b0;
    for (int k = 0; k < W; k++) if (TB_TAPS[k]) b ^= gen_hist[k];
    gen_hist.push_front(b);
    if (gen_hist.size() > W) void'(gen_hist.pop_back());
    return b;
  endfunction

  // ---------------- reference model
  typedef enum {M_SEED, M_ACQ, M_LOCK} mmode_t;
  mmode_t m_mode;
  bit     m_hist[$];
  int     m_fill, m_run, m_wbeats, m_werrs;
  bit     exp_locked, exp_err;
  int     exp_err_cnt, exp_bit_cnt;

  function automatic bit m_predict();
    bit p = 1'b0;
    for (int k = 0; k < W; k++) if (TB_TAPS[k]) p ^= m_hist[k];
    return p;
  endfunction

  function automatic void m_push(bit b);
    m_hist.push_front(b);
    if (m_hist.size() > W) void'(m_hist.pop_back());
  endfunction

  function automatic bit m_any_one();
    bit a = 1'b0;
    for (int k = 0; k < W; k++) a |= m_hist[k];
    return a;
  endfunction

  function automatic void model_reset();
    m_hist.delete();
    for (int k = 0; k < W; k++) m_hist.push_front(1'b0);
    m_mode = M_SEED;
    m_fill = 0; m_run = 0; m_wbeats = 0; m_werrs = 0;
    exp_locked = 1'b0; exp_err = 1'b0; exp_err_cnt = 0; exp_bit_cnt = 0;
  endfunction

  function automatic void model_beat(bit valid, bit b, bit clr);
    bit p = m_predict();
    exp_err = 1'b0;
    if (valid) begin
      case (m_mode)
        M_SEED: begin
          m_push(b);
          m_fill++;
          if (m_fill == W) begin
            m_fill = 0;
            if (m_any_one()) m_mode = M_ACQ;
          end
        end
        M_ACQ: begin
          m_push(b);
          if (b == p) begin
            m_run++;
            if (m_run == LC) begin
              m_mode = M_LOCK; m_run = 0; m_wbeats = 0; m_werrs = 0;
            end
          end else begin
            m_run = 0; m_fill = 0; m_mode = M_SEED;
          end
        end
        default: begin
          m_push(p);
          if (exp_bit_cnt < CMAX) exp_bit_cnt++;
          if (b != p) begin
            exp_err = 1'b1;
            if (exp_err_cnt < CMAX) exp_err_cnt++;
            m_werrs++;
          end
          m_wbeats++;
          if (m_werrs == UE) begin
            m_mode = M_SEED; m_fill = 0; m_run = 0; m_wbeats = 0; m_werrs = 0;
          end else if (m_wbeats == WIN) begin
            m_wbeats = 0; m_werrs = 0;
          end
        end
      endcase
    end
    if (clr) begin
      exp_err_cnt = 0;
      exp_bit_cnt = 0;
    end
    exp_locked = (m_mode == M_LOCK);
  endfunction

  // ---------------- stimulus tasks (no checking)
  task automatic beat(input bit b, input bit clr);
    i_valid = 1'b1; i_bit = b; i_clear = clr;
    @(posedge i_clk);
    model_beat(1'b1, b, clr);
    #1;
    i_valid = 1'b0; i_clear = 1'b0;
  endtask

  task automatic idle(input bit clr);
    i_valid = 1'b0; i_bit = 1'($urandom); i_clear = clr;
    @(posedge i_clk);
    model_beat(1'b0, 1'b0, clr);
    #1;
    i_clear = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_clear = 1'b0; i_bit = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();
    gen_hist.delete();
  endtask

  task automatic send_seed(input logic [3:0] s);
    for (int k = W - 1; k >= 0; k--) begin
      gen_hist.push_front(s[k]);
      beat(s[k], 1'b0);
    end
  endtask

  task automatic relock();
    logic [3:0] s;
    do_reset();
    s = 4'($urandom_range(1, 15));
    send_seed(s);
    for (int k = 0; k < LC; k++) beat(gen_next(), 1'b0);
  endtask

  bit errpos[1:128];

  function automatic void place_errors(int lo, int hi, int n);
    int placed = 0;
    while (placed < n) begin
      int idx = int'($urandom_range(hi, lo));
      if (!errpos[idx]) begin
        errpos[idx] = 1'b1;
        placed++;
      end
    end
  endfunction

  function automatic void clear_errpos();
    for (int k = 1; k <= 128; k++) errpos[k] = 1'b0;
  endfunction

  // ---------------- scenarios
  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    tests_run++;
    if ({o_locked, o_err} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_flags: locked/err=%b expected 00", {o_locked, o_err});
    end
    tests_run++;
    if ({o_err_cnt, o_bit_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL reset_counts: err_cnt=%0d bit_cnt=%0d expected 0/0", o_err_cnt, o_bit_cnt);
    end
    i_rst = 1'b0;
    model_reset();
    gen_hist.delete();
  endtask

  task automatic test_lock_acquisition();
    bit exp_c;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      if (i <= W) begin
        logic [3:0] s = 4'b0001;
        gen_hist.push_front(s[W-i]);
        beat(s[W-i], 1'b0);
      end else begin
        beat(gen_next(), 1'b0);
      end
      exp_c = (i >= 12);
      tests_run++;
      if (o_locked !== exp_c || o_locked !== exp_locked || o_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL lock_acq beat %0d: locked=%b err=%b expected locked=%b err=0",
                 i, o_locked, o_err, exp_c);
      end
    end
    tests_run++;
    if (o_err_cnt !== '0) begin
      tests_failed++;
      $display("FAIL lock_acq_errcnt: got %0d expected 0", o_err_cnt);
    end
  endtask

  task automatic test_single_error();
    relock();
    repeat (int'($urandom_range(1, 10))) beat(gen_next(), 1'b0);
    beat(~gen_next(), 1'b0);
    tests_run++;
    if (o_err !== 1'b1 || o_err_cnt !== CW'(1) || o_locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_err: err=%b err_cnt=%0d locked=%b expected 1/1/1",
               o_err, o_err_cnt, o_locked);
    end
    for (int i = 0; i < 20; i++) begin
      beat(gen_next(), 1'b0);
      tests_run++;
      if (o_err !== 1'b0 || o_locked !== 1'b1) begin
        tests_failed++;
        $display("FAIL flywheel beat %0d: err=%b locked=%b expected 0/1", i, o_err, o_locked);
      end
    end
    tests_run++;
    if (o_err_cnt !== CW'(1)) begin
      tests_failed++;
      $display("FAIL flywheel_errcnt: got %0d expected 1", o_err_cnt);
    end
  endtask

  task automatic test_loss_of_lock();
    int errs = 0;
    relock();
    clear_errpos();
    place_errors(1, 64, UE);
    for (int pos = 1; pos <= 64; pos++) begin
      bit b = gen_next() ^ errpos[pos];
      beat(b, 1'b0);
      if (errpos[pos]) errs++;
      tests_run++;
      if (o_locked !== (errs < UE) || o_locked !== exp_locked || o_err !== errpos[pos]) begin
        tests_failed++;
        $display("FAIL unlock beat %0d: locked=%b err=%b expected locked=%b err=%b",
                 pos, o_locked, o_err, (errs < UE), errpos[pos]);
      end
      if (errs == UE) break;
    end
    tests_run++;
    if (o_err_cnt !== CW'(UE)) begin
      tests_failed++;
      $display("FAIL unlock_errcnt: got %0d expected %0d", o_err_cnt, UE);
    end
    for (int i = 1; i <= W + LC; i++) begin
      beat(gen_next(), 1'b0);
      tests_run++;
      if (o_locked !== (i == W + LC) || o_locked !== exp_locked) begin
        tests_failed++;
        $display("FAIL relock beat %0d: locked=%b expected %b", i, o_locked, (i == W + LC));
      end
    end
  endtask

  task automatic test_window_boundary();
    relock();
    clear_errpos();
    errpos[64] = 1'b1;
    place_errors(1, 63, UE - 2);
    place_errors(65, 128, UE - 1);
    for (int pos = 1; pos <= 128; pos++) begin
      beat(gen_next() ^ errpos[pos], 1'b0);
      tests_run++;
      if (o_locked !== 1'b1 || o_err !== errpos[pos]) begin
        tests_failed++;
        $display("FAIL window beat %0d: locked=%b err=%b expected 1/%b",
                 pos, o_locked, o_err, errpos[pos]);
      end
    end
    tests_run++;
    if (o_err_cnt !== CW'(2 * (UE - 1)) || o_bit_cnt !== CW'(128)) begin
      tests_failed++;
      $display("FAIL window_counts: err_cnt=%0d bit_cnt=%0d expected %0d/128",
               o_err_cnt, o_bit_cnt, 2 * (UE - 1));
    end
  endtask

  task automatic test_clear_collision();
    relock();
    for (int i = 0; i < 5; i++) begin
      beat(~gen_next(), 1'b0);
      beat(gen_next(), 1'b0);
      beat(gen_next(), 1'b0);
    end
    tests_run++;
    if (o_err_cnt !== CW'(5)) begin
      tests_failed++;
      $display("FAIL clear_pre: err_cnt=%0d expected 5", o_err_cnt);
    end
    beat(~gen_next(), 1'b1);
    tests_run++;
    if (o_err !== 1'b1 || o_err_cnt !== '0 || o_bit_cnt !== '0 || o_locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_collide: err=%b err_cnt=%0d bit_cnt=%0d locked=%b expected 1/0/0/1",
               o_err, o_err_cnt, o_bit_cnt, o_locked);
    end
    beat(~gen_next(), 1'b0);
    tests_run++;
    if (o_err_cnt !== CW'(1) || o_bit_cnt !== CW'(1)) begin
      tests_failed++;
      $display("FAIL clear_post: err_cnt=%0d bit_cnt=%0d expected 1/1", o_err_cnt, o_bit_cnt);
    end
  endtask

  task automatic test_all_zero();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) idle(1'b0);
      beat(1'b0, 1'b0);
      tests_run++;
      if (o_locked !== 1'b0 || o_err !== 1'b0 || o_locked !== exp_locked) begin
        tests_failed++;
        $display("FAIL all_zero beat %0d: locked=%b err=%b expected 0/0", i, o_locked, o_err);
      end
    end
  endtask

  task automatic test_random_gaps();
    relock();
    for (int i = 0; i < 500; i++) begin
      bit flip = ($urandom_range(0, 11) == 0);
      bit clr  = ($urandom_range(0, 79) == 0);
      beat(gen_next() ^ flip, clr);
      tests_run++;
      if (o_locked !== exp_locked || o_err !== exp_err ||
          o_err_cnt !== CW'(exp_err_cnt) || o_bit_cnt !== CW'(exp_bit_cnt)) begin
        tests_failed++;
        $display("FAIL random beat %0d: got %b/%b/%0d/%0d expected %b/%b/%0d/%0d", i,
                 o_locked, o_err, o_err_cnt, o_bit_cnt,
                 exp_locked, exp_err, exp_err_cnt, exp_bit_cnt);
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat (int'($urandom_range(1, 3))) begin
          idle(1'b0);
          tests_run++;
          if (o_locked !== exp_locked || o_err !== 1'b0 ||
              o_err_cnt !== CW'(exp_err_cnt) || o_bit_cnt !== CW'(exp_bit_cnt)) begin
            tests_failed++;
            $display("FAIL gap after beat %0d: got %b/%b/%0d/%0d expected %b/0/%0d/%0d", i,
                     o_locked, o_err, o_err_cnt, o_bit_cnt,
                     exp_locked, exp_err_cnt, exp_bit_cnt);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    relock();
    repeat (5) beat(gen_next(), 1'b0);
    beat(~gen_next(), 1'b0);
    tests_run++;
    if (o_locked !== 1'b1 || o_err_cnt !== CW'(1)) begin
      tests_failed++;
      $display("FAIL async_pre: locked=%b err_cnt=%0d expected 1/1", o_locked, o_err_cnt);
    end
    #2;
    i_rst = 1'b1;
    #1;
    tests_run++;
    if ({o_locked, o_err} !== 2'b00 || o_err_cnt !== '0 || o_bit_cnt !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: locked=%b err=%b err_cnt=%0d bit_cnt=%0d expected all 0",
               o_locked, o_err, o_err_cnt, o_bit_cnt);
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();
    gen_hist.delete();
  endtask

  initial begin
    test_reset();
    test_lock_acquisition();
    test_single_error();
    test_loss_of_lock();
    test_window_boundary();
    test_clear_collision();
    test_all_zero();
    test_random_gaps();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
